// File: rtl/udp_cmd_pkg.sv
// Shared types for the UDP command reader: frame FSM states and reject codes.
package udp_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_SHORT = 2'd1,
    ERR_LONG  = 2'd2,
    ERR_CHAN  = 2'd3
  } err_code_t;

endpackage

// File: rtl/udp_cmd_reader.sv
// Captures fixed-length UDP command payloads into per-channel output slices.
// A frame is one channel-select header byte plus CAPACITY payload bytes,
// closed by rx_end. Frames are checked for length and channel before commit.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for the channel-select header byte
//   PAYLOAD | collecting payload bytes into the staging buffer
//   DROP    | frame already rejected; swallow bytes until rx_end
module udp_cmd_reader
  import udp_cmd_pkg::*;
#(
  parameter int CAPACITY  = 4,
  parameter int CHANNELS  = 4,
  parameter int ZERO_TRIG = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid,
  input  logic                         rx_end,
  input  logic [7:0]                   i_data,
  output logic [CHANNELS*CAPACITY*8-1:0] o_data,
  output logic [CHANNELS-1:0]          o_update,
  output logic                         trig,
  output logic                         error,
  output logic [1:0]                   err_code,
  output logic [15:0]                  frame_cnt
);

  localparam int SLICE_W = CAPACITY * 8;
  localparam int CNT_W   = $clog2(CAPACITY + 1);
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CAPACITY);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  err_code_t         rsn_q, rsn_d;
  logic [7:0]        stage_q [CAPACITY];

  logic              hdr_ok;
  logic              wr_en;
  logic [SLICE_W-1:0] payload;
  logic              pl_zero;
  logic              do_commit;
  logic              do_trig;
  logic              do_err;
  err_code_t         code_d;

  // Header range check (9-bit compare so CHANNELS=256 accepts every byte)
  // and the staging write strobe, kept apart from the FSM so the
  // zero-payload detect below does not loop back through it.
  always_comb begin
    hdr_ok = ({1'b0, i_data} < 9'(CHANNELS));
    wr_en  = (state_q == PAYLOAD) && valid && (cnt_q < CNT_FULL);
  end

  // Payload as it will look after this cycle's byte lands; the first byte
  // goes to the MSB so a same-cycle last byte is seen by the commit.
  always_comb begin
    payload = '0;
    for (int i = 0; i < CAPACITY; i++) begin
      if (wr_en && (cnt_q == CNT_W'(i))) begin
        payload[(CAPACITY-i)*8-1 -: 8] = i_data;
      end else begin
        payload[(CAPACITY-i)*8-1 -: 8] = stage_q[i];
      end
    end
    pl_zero = (payload == '0);
  end

  // Next-state logic: consume this cycle's byte first, then, on rx_end,
  // judge the frame using the post-byte state and return to IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    rsn_d     = rsn_q;
    do_commit = 1'b0;
    do_trig   = 1'b0;
    do_err    = 1'b0;
    code_d    = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (valid) begin
          if (hdr_ok) begin
            ch_d    = i_data[CH_W-1:0];
            cnt_d   = '0;
            state_d = PAYLOAD;
          end else begin
            rsn_d   = ERR_CHAN;
            state_d = DROP;
          end
        end
      end
      PAYLOAD: begin
        if (valid) begin
          if (cnt_q < CNT_FULL) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            rsn_d   = ERR_LONG;
            state_d = DROP;
          end
        end
      end
      DROP: begin
      end
      default: state_d = IDLE;
    endcase

    if (rx_end) begin
      case (state_d)
        PAYLOAD: begin
          if (cnt_d == CNT_FULL) begin
            if (pl_zero && (ZERO_TRIG != 0)) begin
              do_trig = 1'b1;
            end else begin
              do_commit = 1'b1;
            end
          end else begin
            do_err = 1'b1;
            code_d = ERR_SHORT;
          end
        end
        DROP: begin
          do_err = 1'b1;
          code_d = rsn_d;
        end
        default: begin
          do_err = 1'b1;
          code_d = ERR_SHORT;
        end
      endcase
      state_d = IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame bookkeeping: byte count (saturates at CAPACITY), channel, reason.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ch_q  <= '0;
      rsn_q <= ERR_NONE;
    end else begin
      cnt_q <= cnt_d;
      ch_q  <= ch_d;
      rsn_q <= rsn_d;
    end
  end

  // Staging buffer; deliberately not cleared between frames since a
  // commit requires every entry to have been rewritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CAPACITY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CAPACITY; i++) begin
        if (wr_en && (cnt_q == CNT_W'(i))) begin
          stage_q[i] <= i_data;
        end
      end
    end
  end

  // Registered outputs: one-cycle pulses, held reject code, channel slices.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data    <= '0;
      o_update  <= '0;
      trig      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      frame_cnt <= '0;
    end else begin
      o_update <= '0;
      trig     <= do_trig;
      error    <= do_err;
      if (do_err) begin
        err_code <= code_d;
      end
      if (do_commit) begin
        frame_cnt <= frame_cnt + 16'd1;
        for (int k = 0; k < CHANNELS; k++) begin
          if (ch_q == CH_W'(k)) begin
            o_data[k*SLICE_W +: SLICE_W] <= payload;
            o_update[k]                  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_cmd_reader.sv
// Directed bench for udp_cmd_reader: a vector table of whole frames plus
// hand-written sequences for back-to-back, bare rx_end and mid-frame reset.
// Two instances share stimulus: dut0 with ZERO_TRIG=1, dut1 with ZERO_TRIG=0.
module tb_udp_cmd_reader;

  localparam int CAP = 4;
  localparam int CH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         valid;
  logic         rx_end;
  logic [7:0]   i_data;

  logic [127:0] o_data0, o_data1;
  logic [3:0]   upd0, upd1;
  logic         trig0, trig1;
  logic         err0, err1;
  logic [1:0]   code0, code1;
  logic [15:0]  fc0, fc1;

  udp_cmd_reader #(.CAPACITY(CAP), .CHANNELS(CH), .ZERO_TRIG(1)) dut0 (
    .clk(clk), .rst(rst), .valid(valid), .rx_end(rx_end), .i_data(i_data),
    .o_data(o_data0), .o_update(upd0), .trig(trig0), .error(err0),
    .err_code(code0), .frame_cnt(fc0)
  );

  udp_cmd_reader #(.CAPACITY(CAP), .CHANNELS(CH), .ZERO_TRIG(0)) dut1 (
    .clk(clk), .rst(rst), .valid(valid), .rx_end(rx_end), .i_data(i_data),
    .o_data(o_data1), .o_update(upd1), .trig(trig1), .error(err1),
    .err_code(code1), .frame_cnt(fc1)
  );

  typedef struct {
    logic [7:0]  hdr;
    int          n;
    logic [47:0] pl;        // first byte in [47:40]
    bit          end_last;  // rx_end shares the cycle of the last byte
    logic [3:0]  upd0;
    logic [3:0]  upd1;
    bit          trg;
    bit          err;
    logic [1:0]  code;
    logic [31:0] val;       // value of the committed slice
  } vec_t;

  vec_t        vecs [9];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m0 [4];
  logic [31:0] m1 [4];
  logic [15:0] c0exp, c1exp;
  logic [1:0]  last_code;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_data0();
    logic [127:0] e;
    for (int k = 0; k < 4; k++) e[k*32 +: 32] = m0[k];
    return e;
  endfunction

  function automatic logic [127:0] exp_data1();
    logic [127:0] e;
    for (int k = 0; k < 4; k++) e[k*32 +: 32] = m1[k];
    return e;
  endfunction

  task automatic idle();
    valid  = 1'b0;
    rx_end = 1'b0;
    i_data = 8'h00;
  endtask

  task automatic clear_models();
    for (int k = 0; k < 4; k++) begin
      m0[k] = '0;
      m1[k] = '0;
    end
    c0exp     = '0;
    c1exp     = '0;
    last_code = 2'd0;
  endtask

  // Drives one frame starting at a falling edge (or right now if now=1).
  // Returns with rx_end still asserted; the caller deasserts it.
  task automatic send_frame(input logic [7:0] hdr, input int n, input logic [47:0] pl,
                            input bit end_last, input bit now);
    if (!now) @(negedge clk);
    valid  = 1'b1;
    i_data = hdr;
    rx_end = 1'b0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      i_data = pl[47-8*j -: 8];
      rx_end = end_last && (j == n - 1);
    end
    if (!end_last || n == 0) begin
      @(negedge clk);
      valid  = 1'b0;
      i_data = 8'h00;
      rx_end = 1'b1;
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_upd0, input logic [3:0] e_upd1,
                           input bit e_trg, input bit e_err);
    check({tag, " o_update"},     upd0,    e_upd0);
    check({tag, " trig"},         trig0,   e_trg);
    check({tag, " error"},        err0,    e_err);
    check({tag, " err_code"},     code0,   last_code);
    check({tag, " o_data"},       o_data0, exp_data0());
    check({tag, " frame_cnt"},    fc0,     c0exp);
    check({tag, " zt0 o_update"}, upd1,    e_upd1);
    check({tag, " zt0 trig"},     trig1,   1'b0);
    check({tag, " zt0 o_data"},   o_data1, exp_data1());
    check({tag, " zt0 frame_cnt"}, fc1,    c1exp);
  endtask

  task automatic check_pulses_gone(input string tag);
    check({tag, " pulses clear"}, {upd0, trig0, err0, upd1, trig1, err1}, '0);
  endtask

  task automatic apply_model(input logic [3:0] u0, input logic [3:0] u1, input logic [31:0] val,
                             input bit e_err, input logic [1:0] code);
    for (int k = 0; k < 4; k++) begin
      if (u0[k]) m0[k] = val;
      if (u1[k]) m1[k] = val;
    end
    if (u0 != 0) c0exp = c0exp + 16'd1;
    if (u1 != 0) c1exp = c1exp + 16'd1;
    if (e_err) last_code = code;
  endtask

  initial begin
    //            hdr    n  payload              last  upd0     upd1     trg err code val
    vecs[0] = '{8'h02, 4, 48'hDEADBEEF_0000,     1'b0, 4'b0100, 4'b0100, 0, 0, 2'd0, 32'hDEADBEEF};
    vecs[1] = '{8'h01, 4, 48'h11223344_0000,     1'b1, 4'b0010, 4'b0010, 0, 0, 2'd0, 32'h11223344};
    vecs[2] = '{8'h01, 4, 48'h00000000_0000,     1'b0, 4'b0000, 4'b0010, 1, 0, 2'd0, 32'h00000000};
    vecs[3] = '{8'h00, 2, 48'h1122_00000000,     1'b0, 4'b0000, 4'b0000, 0, 1, 2'd1, 32'h0};
    vecs[4] = '{8'h00, 5, 48'h1122334455_00,     1'b0, 4'b0000, 4'b0000, 0, 1, 2'd2, 32'h0};
    vecs[5] = '{8'h03, 5, 48'h0102030405_00,     1'b1, 4'b0000, 4'b0000, 0, 1, 2'd2, 32'h0};
    vecs[6] = '{8'h00, 0, 48'h0,                 1'b0, 4'b0000, 4'b0000, 0, 1, 2'd1, 32'h0};
    vecs[7] = '{8'h04, 4, 48'h11223344_0000,     1'b0, 4'b0000, 4'b0000, 0, 1, 2'd3, 32'h0};
    vecs[8] = '{8'h00, 4, 48'h0A0B0C0D_0000,     1'b0, 4'b0001, 4'b0001, 0, 0, 2'd0, 32'h0A0B0C0D};

    clear_models();
    idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].hdr, vecs[v].n, vecs[v].pl, vecs[v].end_last, 1'b0);
      @(negedge clk);
      idle();
      apply_model(vecs[v].upd0, vecs[v].upd1, vecs[v].val, vecs[v].err, vecs[v].code);
      check_all($sformatf("vec%0d", v), vecs[v].upd0, vecs[v].upd1, vecs[v].trg, vecs[v].err);
      @(negedge clk);
      check_pulses_gone($sformatf("vec%0d", v));
    end

    // Bad channel, then a header in the very next cycle after rx_end.
    send_frame(8'h07, 4, 48'h11223344_0000, 1'b0, 1'b0);
    @(negedge clk);
    apply_model(4'b0000, 4'b0000, 32'h0, 1'b1, 2'd3);
    check_all("badch", 4'b0000, 4'b0000, 1'b0, 1'b1);
    send_frame(8'h03, 4, 48'hAABBCCDD_0000, 1'b0, 1'b1);
    @(negedge clk);
    idle();
    apply_model(4'b1000, 4'b1000, 32'hAABBCCDD, 1'b0, 2'd0);
    check_all("b2b", 4'b1000, 4'b1000, 1'b0, 1'b0);
    @(negedge clk);
    check_pulses_gone("b2b");

    // rx_end with no bytes at all.
    rx_end = 1'b1;
    @(negedge clk);
    idle();
    apply_model(4'b0000, 4'b0000, 32'h0, 1'b1, 2'd1);
    check_all("bare_end", 4'b0000, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    check_pulses_gone("bare_end");

    // Reset in the middle of a frame.
    @(negedge clk); valid = 1'b1; i_data = 8'h03;
    @(negedge clk); i_data = 8'h12;
    @(negedge clk); i_data = 8'h34;
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk);
    clear_models();
    check_all("midrst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_pulses_gone("midrst");

    send_frame(8'h00, 4, 48'h01020304_0000, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    apply_model(4'b0001, 4'b0001, 32'h01020304, 1'b0, 2'd0);
    check_all("postrst", 4'b0001, 4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    check_pulses_gone("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
